memory_stage: RTL

- Pipeline stage directly downstream of the execute stage. Consumes the EX/MEM pipeline register and performs data-memory loads and stores over a req/ack handshake.
- Applies byte enables, store-data alignment and load sign/zero extension.
- Drives mem_hold to freeze the upstream stages while an access is outstanding, and produces the MEM/WB pipeline register.

---
 rtl/memory_stage_if.sv | 15 +
 rtl/memory_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the data memory (slave).
interface memory_stage_if #(parameter int ADDR_W = 32);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  input  dmem_rdata, dmem_ack);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  output dmem_rdata, dmem_ack);
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: req/ack data-memory access with byte lanes, load extension and MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned HW/W accesses skip the bus and pulse misalign_err.
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_regwrite,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_mulres,
  input  logic [31:0] EX_MEM_divres,
  input  logic        EX_MEM_mul_ready,
  input  logic        EX_MEM_div_ready,
  input  logic [31:0] EX_MEM_dout_rs2,
  input  logic [4:0]  EX_MEM_loadcntrl,
  input  logic [2:0]  EX_MEM_storecntrl,
  memory_stage_if.master dmem,
  output logic        mem_hold,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_regwrite,
  output logic        MEM_WB_memread,
  output logic [31:0] MEM_WB_alures,
  output logic [31:0] MEM_WB_memres,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic      misalign_err
`endif
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic [31:0] alures;
    logic [31:0] memres;
  } mw_t;

  state_t            state_q, state_d;
  logic              req_q, we_q, ack_seen_q, bus_err_q, trap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, be_c;
  logic [31:0]       wdata_q, wdata_c, rdata_q, memres_c, res_sel, shifted, word_addr;
  logic [15:0]       half;
  logic [CW-1:0]     cnt_q;
  mw_t               mw_q;
  logic              access, misalign, hold_c, ack_any, timeout;
  logic [1:0]        a;

  assign a         = EX_MEM_alures[1:0];
  assign access    = (EX_MEM_memread | EX_MEM_memwrite) & ~dbg;
  assign ack_any   = dmem.dmem_ack | ack_seen_q;
  assign timeout   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign word_addr = {EX_MEM_alures[31:2], 2'b00};
  assign res_sel   = EX_MEM_mul_ready ? EX_MEM_mulres :
                     EX_MEM_div_ready ? EX_MEM_divres : EX_MEM_alures;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = EX_MEM_memwrite ?
      ((EX_MEM_storecntrl[1] & a[0]) | (EX_MEM_storecntrl[2] & (|a))) :
      (((EX_MEM_loadcntrl[1] | EX_MEM_loadcntrl[4]) & a[0]) | (EX_MEM_loadcntrl[2] & (|a)));
  assign misalign_err = trap_q;
`else
  assign misalign = 1'b0;
`endif

  // Store lanes; halfwords are naturally aligned on a[1] so a stray a[0] is ignored.
  always_comb begin
    be_c    = 4'hF;
    wdata_c = EX_MEM_dout_rs2;
    if (EX_MEM_memwrite) begin
      if (EX_MEM_storecntrl[0]) begin
        be_c    = 4'b0001 << a;
        wdata_c = {4{EX_MEM_dout_rs2[7:0]}};
      end else if (EX_MEM_storecntrl[1]) begin
        be_c    = 4'b0011 << {a[1], 1'b0};
        wdata_c = {2{EX_MEM_dout_rs2[15:0]}};
      end else if (EX_MEM_storecntrl[2]) begin
        be_c    = 4'hF;
        wdata_c = EX_MEM_dout_rs2;
      end
    end
  end

  always_comb begin
    shifted  = rdata_q >> {a, 3'b000};
    half     = a[1] ? rdata_q[31:16] : rdata_q[15:0];
    memres_c = rdata_q;
    if      (EX_MEM_loadcntrl[0]) memres_c = {{24{shifted[7]}}, shifted[7:0]};
    else if (EX_MEM_loadcntrl[1]) memres_c = {{16{half[15]}}, half};
    else if (EX_MEM_loadcntrl[2]) memres_c = rdata_q;
    else if (EX_MEM_loadcntrl[3]) memres_c = {24'h0, shifted[7:0]};
    else if (EX_MEM_loadcntrl[4]) memres_c = {16'h0, half};
  end

  always_comb begin
    state_d = state_q;
    hold_c  = 1'b0;
    case (state_q)
      IDLE: if (access) begin
        hold_c  = 1'b1;
        state_d = misalign ? RESP : WAIT;
      end
      WAIT: begin
        hold_c = 1'b1;
        if (!dbg && (ack_any || timeout)) state_d = RESP;
      end
      RESP:    if (!dbg) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_hold = hold_c & ~Rst;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      ack_seen_q <= 1'b0;
      bus_err_q  <= 1'b0;
      trap_q     <= 1'b0;
      mw_q       <= '0;
    end else if (dbg) begin
      // Frozen, but a completion arriving now must not be lost.
      if (state_q == WAIT && dmem.dmem_ack && !ack_seen_q) begin
        rdata_q    <= dmem.dmem_rdata;
        ack_seen_q <= 1'b1;
      end
    end else begin
      state_q   <= state_d;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: if (access) begin
          if (misalign) begin
            trap_q  <= 1'b1;
            rdata_q <= '0;
          end else begin
            req_q   <= 1'b1;
            we_q    <= EX_MEM_memwrite;
            addr_q  <= word_addr[ADDR_W-1:0];
            be_q    <= be_c;
            wdata_q <= wdata_c;
          end
          cnt_q      <= '0;
          ack_seen_q <= 1'b0;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (ack_any) begin
            req_q      <= 1'b0;
            ack_seen_q <= 1'b0;
            if (!ack_seen_q) rdata_q <= dmem.dmem_rdata;
          end else if (timeout) begin
            req_q     <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
          end
        end
        RESP:    trap_q <= 1'b0;
        default: ;
      endcase
      if (hold_c) mw_q.regwrite <= 1'b0;
      else        mw_q <= {EX_MEM_rd, EX_MEM_regwrite & ~trap_q,
                           EX_MEM_memread & ~EX_MEM_memwrite, res_sel, memres_c};
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign MEM_WB_rd       = mw_q.rd;
  assign MEM_WB_regwrite = mw_q.regwrite;
  assign MEM_WB_memread  = mw_q.memread;
  assign MEM_WB_alures   = mw_q.alures;
  assign MEM_WB_memres   = mw_q.memres;
  assign bus_err         = bus_err_q;
endmodule
